// File: rtl/dm_access_ctrl.sv
// Two-port sequencer/arbiter in front of one word-wide synchronous RAM.
// Handles byte/half/word loads and stores; sub-word stores are read-merge-write.
module dm_access_ctrl #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic [31:0]       p0_addr,
  input  logic [1:0]        p0_width,
  input  logic              p0_extend,
  input  logic              p0_we,
  input  logic [31:0]       p0_wd,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic [31:0]       p1_addr,
  input  logic [1:0]        p1_width,
  input  logic              p1_extend,
  input  logic              p1_we,
  input  logic [31:0]       p1_wd,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [31:0]       p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

  state_t      state, state_nx;
  logic        last_grant;
  logic        q_port, q_we, q_ext;
  logic [1:0]  q_width, q_lane;
  logic [31:0] q_wd;

  logic        gnt_any, gnt_port, sel_err, sel_we, sel_ext;
  logic [31:0] sel_addr, sel_wd;
  logic [1:0]  sel_width;
  logic        going_resp, resp_port;
  logic [31:0] merged, shifted, load_val;
  logic        unused_addr_bits;

  // Round-robin: on a tie the port that did not win last time is granted.
  assign gnt_any   = p0_req | p1_req;
  assign gnt_port  = p0_req ? (p1_req & ~last_grant) : 1'b1;
  assign sel_addr  = gnt_port ? p1_addr   : p0_addr;
  assign sel_width = gnt_port ? p1_width  : p0_width;
  assign sel_ext   = gnt_port ? p1_extend : p0_extend;
  assign sel_we    = gnt_port ? p1_we     : p0_we;
  assign sel_wd    = gnt_port ? p1_wd     : p0_wd;
  assign unused_addr_bits = ^sel_addr[31:ADDR_W+2];

  always_comb begin
    sel_err = 1'b0;
    case (sel_width)
      2'b01:   sel_err = sel_addr[0];
      2'b10:   sel_err = |sel_addr[1:0];
      2'b11:   sel_err = 1'b1;
      default: sel_err = 1'b0;
    endcase
  end

  always_comb begin
    merged = mem_rd;
    case (q_width)
      2'b00:   merged[{q_lane, 3'b000} +: 8]     = q_wd[7:0];
      2'b01:   merged[{q_lane[1], 4'b0000} +: 16] = q_wd[15:0];
      default: merged = mem_rd;
    endcase
  end

  always_comb begin
    shifted = mem_rd >> {q_lane, 3'b000};
    case (q_width)
      2'b00:   load_val = {{24{q_ext & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{q_ext & shifted[15]}}, shifted[15:0]};
      default: load_val = mem_rd;
    endcase
  end

  always_comb begin
    state_nx = state;
    mem_we   = 1'b0;
    mem_wd   = '0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          if (sel_err)                           state_nx = RESP;
          else if (sel_we && sel_width == 2'b10) state_nx = WR;
          else                                   state_nx = RD;
        end
      end
      RD:    state_nx = MERGE;
      MERGE: begin
        if (q_we) begin
          mem_we = 1'b1;
          mem_wd = merged;
        end
        state_nx = RESP;
      end
      WR: begin
        mem_we   = 1'b1;
        mem_wd   = q_wd;
        state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Errors jump straight from IDLE to RESP before the request register is
  // loaded, so the responding port comes from the live grant in that case.
  assign going_resp = (state_nx == RESP);
  assign resp_port  = (state == IDLE) ? gnt_port : q_port;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      q_port     <= 1'b0;
      q_we       <= 1'b0;
      q_ext      <= 1'b0;
      q_width    <= '0;
      q_lane     <= '0;
      q_wd       <= '0;
      mem_addr   <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_err     <= 1'b0;
      p1_err     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && gnt_any) begin
        last_grant <= gnt_port;
        q_port     <= gnt_port;
        q_we       <= sel_we;
        q_ext      <= sel_ext;
        q_width    <= sel_width;
        q_lane     <= sel_addr[1:0];
        q_wd       <= sel_wd;
        if (!sel_err) mem_addr <= sel_addr[ADDR_W+1:2];
      end
      p0_ack   <= going_resp & ~resp_port;
      p1_ack   <= going_resp &  resp_port;
      p0_err   <= going_resp & ~resp_port & (state == IDLE);
      p1_err   <= going_resp &  resp_port & (state == IDLE);
      p0_rdata <= (state == MERGE && !q_we && !q_port) ? load_val : '0;
      p1_rdata <= (state == MERGE && !q_we &&  q_port) ? load_val : '0;
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed vector table, reset-abort and arbitration
// sequences, then random single-port traffic against a byte-addressed model.
module tb_dm_access_ctrl;

  logic        clk, rst_n;
  logic        p0_req, p0_extend, p0_we, p0_ack, p0_err;
  logic [31:0] p0_addr, p0_wd, p0_rdata;
  logic [1:0]  p0_width;
  logic        p1_req, p1_extend, p1_we, p1_ack, p1_err;
  logic [31:0] p1_addr, p1_wd, p1_rdata;
  logic [1:0]  p1_width;
  logic [11:0] mem_addr;
  logic        mem_we, busy;
  logic [31:0] mem_wd, mem_rd;

  int n_vec = 0;
  int n_err = 0;

  dm_access_ctrl #(.ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_width(p0_width), .p0_extend(p0_extend),
    .p0_we(p0_we), .p0_wd(p0_wd), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_width(p1_width), .p1_extend(p1_extend),
    .p1_we(p1_we), .p1_wd(p1_wd), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: read data appears the cycle after the address.
  logic [31:0] ram [0:4095];
  logic        ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wd;
      mem_rd <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic port, input logic [31:0] addr, input logic [1:0] width,
                       input logic ext, input logic we, input logic [31:0] wd,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output int wes, output int we_cyc, output logic other_ack);
    if (port) begin
      p1_addr = addr; p1_width = width; p1_extend = ext; p1_we = we; p1_wd = wd; p1_req = 1'b1;
    end else begin
      p0_addr = addr; p0_width = width; p0_extend = ext; p0_we = we; p0_wd = wd; p0_req = 1'b1;
    end
    lat = 0; wes = 0; we_cyc = 0; other_ack = 1'b0; rdata = '0; err = 1'b0;
    while (lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (mem_we) begin wes++; we_cyc = lat; end
      if (port ? p0_ack : p1_ack) other_ack = 1'b1;
      if (port ? p1_ack : p0_ack) begin
        rdata = port ? p1_rdata : p0_rdata;
        err   = port ? p1_err : p0_err;
        break;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [1:0]  width;
    logic        ext;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_cyc;
  } vec_t;

  vec_t        tbl[$];
  logic [7:0]  rb[32];

  initial begin
    int lat, wes, we_cyc;
    logic [31:0] rdata;
    logic err, other;

    rst_n = 1'b0; ram_clr = 1'b1;
    p0_req = 0; p0_addr = '0; p0_width = '0; p0_extend = 0; p0_we = 0; p0_wd = '0;
    p1_req = 0; p1_addr = '0; p1_width = '0; p1_extend = 0; p1_we = 0; p1_wd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ack", {p0_ack, p1_ack, p0_err, p1_err}, 0);
    chk("rst_rdata", p0_rdata | p1_rdata, 0);
    chk("rst_mem", {mem_we, mem_addr}, 0);
    chk("rst_wd", mem_wd, 0);
    ram_clr = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // port, addr, width, ext, we, wd, exp rdata, exp err, exp latency, exp write cycle
    tbl.push_back('{1'b0, 32'h10, 2'd2, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1});
    tbl.push_back('{1'b0, 32'h10, 2'd2, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0});
    tbl.push_back('{1'b0, 32'h20, 2'd2, 1'b0, 1'b1, 32'h11223344, 32'h0,        1'b0, 2, 1});
    tbl.push_back('{1'b1, 32'h22, 2'd0, 1'b0, 1'b1, 32'h000000AA, 32'h0,        1'b0, 3, 2});
    tbl.push_back('{1'b1, 32'h20, 2'd2, 1'b0, 1'b0, 32'h0,        32'h11AA3344, 1'b0, 3, 0});
    tbl.push_back('{1'b0, 32'h23, 2'd0, 1'b1, 1'b0, 32'h0,        32'h00000011, 1'b0, 3, 0});
    tbl.push_back('{1'b0, 32'h22, 2'd1, 1'b0, 1'b1, 32'hFFFF8AAA, 32'h0,        1'b0, 3, 2});
    tbl.push_back('{1'b1, 32'h22, 2'd1, 1'b1, 1'b0, 32'h0,        32'hFFFF8AAA, 1'b0, 3, 0});
    tbl.push_back('{1'b1, 32'h22, 2'd1, 1'b0, 1'b0, 32'h0,        32'h00008AAA, 1'b0, 3, 0});
    tbl.push_back('{1'b0, 32'h20, 2'd0, 1'b1, 1'b0, 32'h0,        32'h00000044, 1'b0, 3, 0});
    tbl.push_back('{1'b1, 32'h21, 2'd0, 1'b0, 1'b0, 32'h0,        32'h00000033, 1'b0, 3, 0});
    tbl.push_back('{1'b0, 32'h23, 2'd0, 1'b1, 1'b0, 32'h0,        32'hFFFFFF8A, 1'b0, 3, 0});
    tbl.push_back('{1'b0, 32'h21, 2'd1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1, 0});
    tbl.push_back('{1'b1, 32'h20, 2'd3, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0});
    tbl.push_back('{1'b0, 32'h22, 2'd2, 1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1, 0});
    tbl.push_back('{1'b1, 32'h20, 2'd2, 1'b0, 1'b0, 32'h0,        32'h8AAA3344, 1'b0, 3, 0});

    foreach (tbl[i]) begin
      do_op(tbl[i].port, tbl[i].addr, tbl[i].width, tbl[i].ext, tbl[i].we, tbl[i].wd,
            lat, rdata, err, wes, we_cyc, other);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].rdata);
      chk($sformatf("vec%0d_err", i), err, tbl[i].err);
      chk($sformatf("vec%0d_we_cyc", i), we_cyc, tbl[i].we_cyc);
      chk($sformatf("vec%0d_we_cnt", i), wes, (tbl[i].we_cyc != 0) ? 1 : 0);
      chk($sformatf("vec%0d_other_ack", i), other, 0);
    end
    chk("ram_0x10", ram[4], 32'hDEADBEEF);
    chk("ram_0x20", ram[8], 32'h8AAA3344);

    // Reset asserted in MERGE of a byte store to 0x24: access aborted, no ack.
    p0_addr = 32'h24; p0_width = 2'd0; p0_extend = 0; p0_we = 1; p0_wd = 32'h5A; p0_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_in_merge_we", mem_we, 1);
    chk("abort_in_merge_addr", mem_addr, 12'd9);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_mem", {mem_we, mem_addr}, 0);
    chk("abort_wd", mem_wd, 0);
    p0_req = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("abort_no_ack", {p0_ack, p1_ack, p0_err, p1_err}, 0);
    end
    chk("abort_ram", ram[9], 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both ports request loads continuously: grants alternate starting at port 0.
    begin
      int acks = 0;
      int since = -1;
      logic expp = 1'b0;
      p0_addr = 32'h10; p0_width = 2'd2; p0_we = 0; p0_extend = 0;
      p1_addr = 32'h20; p1_width = 2'd2; p1_we = 0; p1_extend = 0;
      p0_req = 1; p1_req = 1;
      for (int c = 0; c < 60 && acks < 8; c++) begin
        @(posedge clk); #1;
        if (since == 0) chk("arb_idle_gap", busy, 0);
        if (since == 1) chk("arb_busy_again", busy, 1);
        if (since >= 0) since++;
        if (p0_ack | p1_ack) begin
          chk("arb_single_ack", p0_ack & p1_ack, 0);
          chk("arb_owner", p1_ack, expp);
          if (p1_ack) begin
            chk("arb_p1_rdata", p1_rdata, 32'h8AAA3344);
            chk("arb_p0_quiet", p0_rdata, 0);
          end else begin
            chk("arb_p0_rdata", p0_rdata, 32'hDEADBEEF);
            chk("arb_p1_quiet", p1_rdata, 0);
          end
          expp = ~expp;
          acks++;
          since = 0;
          if (acks == 8) begin p0_req = 0; p1_req = 0; end
        end
      end
      chk("arb_ack_count", acks, 8);
      p0_req = 0; p1_req = 0;
      @(posedge clk); #1;
    end

    // Random traffic on words 0x100..0x11F against a byte-level model.
    foreach (rb[k]) rb[k] = 8'h00;
    for (int n = 0; n < 150; n++) begin
      logic        port, ext, we, e_err;
      logic [1:0]  w;
      logic [31:0] a, wd;
      logic [63:0] v;
      int          nb, off, e_lat, e_wcyc;
      port = 1'($urandom_range(0, 1));
      a    = 32'h100 + $urandom_range(0, 31);
      w    = 2'($urandom_range(0, 3));
      ext  = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      nb   = 1 << w;
      off  = int'(a - 32'h100);
      e_err = (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'b00);
      v = '0;
      if (!e_err) begin
        if (we) begin
          for (int i = 0; i < nb; i++) rb[off + i] = wd[8*i +: 8];
        end else begin
          for (int i = 0; i < nb; i++) v = v | (64'(rb[off + i]) << (8 * i));
          if (ext && v[8*nb - 1]) v = v | (~64'h0 << (8 * nb));
        end
      end
      e_lat  = e_err ? 1 : (we && w == 2'd2) ? 2 : 3;
      e_wcyc = (e_err || !we) ? 0 : (w == 2'd2) ? 1 : 2;
      do_op(port, a, w, ext, we, wd, lat, rdata, err, wes, we_cyc, other);
      chk("rand_lat", lat, e_lat);
      chk("rand_rdata", rdata, (e_err || we) ? 32'h0 : v[31:0]);
      chk("rand_err", err, e_err);
      chk("rand_we_cyc", we_cyc, e_wcyc);
      chk("rand_other_ack", other, 0);
    end
    for (int k = 0; k < 8; k++)
      chk($sformatf("rand_ram%0d", k), ram[64 + k], {rb[4*k+3], rb[4*k+2], rb[4*k+1], rb[4*k]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Multi-cycle sequencer and arbiter sharing one word-wide synchronous data RAM between two requesters: port 0 is the CPU data port, port 1 is the debug/DMA port.
- Performs byte, halfword and word loads and stores.
- Sub-word stores are done as read-modify-write sequences (read, merge, write), so the RAM is never written with stale neighbouring bytes.
- Sits between the requesters and the RAM macro; owns mem_addr, mem_we and mem_wd exclusively.

Parameters:
- ADDR_W, 12, RAM word-address width; mem_addr = addr[ADDR_W+1:2].

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- pN_req  in  1  request valid (N = 0,1; hold stable with fields until pN_ack)
- pN_addr  in  32  byte address
- pN_width  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- pN_extend  in  1  load extension: 1 sign, 0 zero
- pN_we  in  1  1 store, 0 load
- pN_wd  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- pN_ack  out  1  registered one-cycle completion pulse
- pN_err  out  1  registered, pulses with pN_ack on misaligned/reserved access
- pN_rdata  out  32  registered load result; valid only while pN_ack=1
- mem_addr  out  ADDR_W  RAM word address
- mem_we  out  1  RAM write enable
- mem_wd  out  32  RAM write data
- mem_rd  in  32  RAM read data, valid the cycle after mem_addr is presented with mem_we=0
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE; all pN_ack, pN_err, mem_we, busy = 0; pN_rdata, mem_wd, mem_addr = 0; last_grant=1, so port 0 wins the first tie.
- States: IDLE, RD, MERGE, WR, RESP.
- IDLE arbitration:
  - Only one req high: that port wins.
  - Both high: port != last_grant wins (round-robin).
  - On grant, latch addr/width/extend/we/wd/port into an internal request register and update last_grant.
- IDLE next-state:
  - Error (width=11, half with addr[0]=1, word with addr[1:0]!=0) -> RESP with err=1. No RAM access.
  - Word store -> WR.
  - Otherwise (any load or sub-word store) -> RD.
- RD: mem_addr=latched word address, mem_we=0 -> MERGE.
- MERGE: mem_rd is valid this cycle.
  - Load: select lane (byte lane addr[1:0], half lane addr[1]), extend per pN_extend, register into rdata_q -> RESP.
  - Sub-word store: mem_wd = mem_rd with the target lane replaced by wd[7:0] or wd[15:0]; mem_we=1 this cycle -> RESP.
- WR: mem_wd=wd, mem_we=1 -> RESP.
- RESP: granted port's pN_ack=1 (pN_err as latched), pN_rdata=rdata_q for loads, 0 for stores/errors; other port's outputs stay 0; -> IDLE.
- mem_we is high only in WR, or in MERGE for a store. mem_addr holds its last value in IDLE.
- Latency (request seen in IDLE at cycle 0, ack cycle):
  - Load / sub-word store: ack in cycle 3.
  - Word store: ack in cycle 2.
  - Error: ack in cycle 1.
- Back-to-back: the controller is in IDLE during the cycle after ack, so req held high there is taken as a new request. Requesters must drop req in the ack cycle if they have no new request.
- Non-granted req is ignored (no ack) until a later IDLE grant; no starvation: with both ports always requesting, grants alternate 0,1,0,1.
- Reset during MERGE or WR aborts the access; a partially issued write completes only if its clock edge precedes reset assertion. No ack is ever produced for an aborted request.

Test Plan:
- Word store p0 addr 0x10 wd 0xDEADBEEF, then word load addr 0x10 -> mem_we pulse in cycle 1; load ack in cycle 3 with p0_rdata=0xDEADBEEF, p0_err=0.
- RAM word 0x11223344 at 0x20: byte store p1 addr 0x22 wd 0xAA -> one RD then MERGE write of 0x11AA3344; ack in cycle 3.
- Same word: lb addr 0x23 extend=1 -> 0x00000011; lh addr 0x22 extend=1 with word 0x8AAA3344 -> 0xFFFF8AAA; extend=0 -> 0x00008AAA.
- Both ports request loads continuously -> grants 0,1,0,1; each ack only on the owning port; busy stays high except the single IDLE cycles.
- Halfword load addr 0x21 and width=11 -> ack+err in cycle 1, rdata=0, mem_we never asserted, RAM unchanged.
- Assert rst_n=0 while in MERGE of a sub-word store -> all outputs 0 immediately, no ack; after release, port 0 wins the first tie.
